operand_fetch_stage: RTL and testbench

- Decode/operand-fetch stage of the 8-bit pipelined CPU.
- Sits between the decoder and the 16 x 8 register file, and feeds the ID/EX pipeline register.
- Drives the register-file read addresses and resolves data hazards by forwarding from EX and WB.
- Stalls on load-use hazards and holds operands in a valid/ready output register.

---
 rtl/operand_fetch_stage.sv | 149 ++++++++++++++
 tb/tb_operand_fetch_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: drives register-file reads, forwards from EX/WB,
// stalls on load-use hazards and holds the ID/EX register. Define OF_STALL_CNT_EN for stall_cnt.
module operand_fetch_stage #(
  parameter int DW  = 8,
  parameter int AW  = 4,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [AW-1:0]  in_rs_a,
  input  logic [AW-1:0]  in_rs_b,
  input  logic [AW-1:0]  in_rd,
  input  logic [DW-1:0]  in_imm,
  input  logic           in_wb_en,
  input  logic           in_is_load,
  output logic [AW-1:0]  rf_read_a,
  output logic [AW-1:0]  rf_read_b,
  input  logic [DW-1:0]  rf_data_a,
  input  logic [DW-1:0]  rf_data_b,
  input  logic           ex_wb_en,
  input  logic [AW-1:0]  ex_dest,
  input  logic [DW-1:0]  ex_data,
  input  logic           ex_is_load,
  input  logic           wb_wb_en,
  input  logic [AW-1:0]  wb_dest,
  input  logic [DW-1:0]  wb_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_op,
  output logic [DW-1:0]  out_a,
  output logic [DW-1:0]  out_b,
  output logic [DW-1:0]  out_imm,
  output logic [AW-1:0]  out_rd,
  output logic           out_wb_en,
`ifdef OF_STALL_CNT_EN
  output logic           out_is_load,
  output logic [15:0]    stall_cnt
`else
  output logic           out_is_load
`endif
);

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [DW-1:0]  imm;
    logic [AW-1:0]  rd;
    logic           wb_en;
    logic           is_load;
  } idex_t;

  logic          out_valid_q, out_valid_d;
  idex_t         payload_q, payload_d;

  logic          ex_fwd_ok;
  logic          hazard;
  logic          accept;
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;

  assign rf_read_a = in_rs_a;
  assign rf_read_b = in_rs_b;

  // A load in EX has no data yet, so it can never be a forwarding source.
  assign ex_fwd_ok = ex_wb_en && !ex_is_load;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    opnd_a = rf_data_a;
    opnd_b = rf_data_b;
    if (ex_fwd_ok && (ex_dest == in_rs_a)) begin
      opnd_a = ex_data;
    end else if (wb_wb_en && (wb_dest == in_rs_a)) begin
      opnd_a = wb_data;
    end
    if (ex_fwd_ok && (ex_dest == in_rs_b)) begin
      opnd_b = ex_data;
    end else if (wb_wb_en && (wb_dest == in_rs_b)) begin
      opnd_b = wb_data;
    end
  end

  assign hazard   = in_valid && ex_wb_en && ex_is_load &&
                    ((ex_dest == in_rs_a) || (ex_dest == in_rs_b));
  assign in_ready = !rst && !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    payload_d   = payload_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      payload_d   = '{op: in_op, a: opnd_a, b: opnd_b, imm: in_imm,
                      rd: in_rd, wb_en: in_wb_en, is_load: in_is_load};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      out_valid_q <= 1'b0;
      // NOTE: payload flops are reset too, so a post-reset bubble presents all zeros downstream.
      payload_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      payload_q   <= payload_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op      = payload_q.op;
  assign out_a       = payload_q.a;
  assign out_b       = payload_q.b;
  assign out_imm     = payload_q.imm;
  assign out_rd      = payload_q.rd;
  assign out_wb_en   = payload_q.wb_en;
  assign out_is_load = payload_q.is_load;

`ifdef OF_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed test-plan steps, then random
// traffic against a cycle-level reference model with its own register-file array.
module tb_operand_fetch_stage;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready;
  logic [3:0] in_op, in_rs_a, in_rs_b, in_rd;
  logic [7:0] in_imm;
  logic       in_wb_en, in_is_load;
  logic [3:0] rf_read_a, rf_read_b;
  logic [7:0] rf_data_a, rf_data_b;
  logic       ex_wb_en, ex_is_load, wb_wb_en;
  logic [3:0] ex_dest, wb_dest;
  logic [7:0] ex_data, wb_data;
  logic       out_valid, out_ready, out_wb_en, out_is_load;
  logic [3:0] out_op, out_rd;
  logic [7:0] out_a, out_b, out_imm;
`ifdef OF_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] m_cnt;
`endif

  always #5 clk = ~clk;

  logic [7:0] rf [16];
  assign rf_data_a = rf[rf_read_a];
  assign rf_data_b = rf[rf_read_b];

  operand_fetch_stage dut (
`ifdef OF_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rd(in_rd), .in_imm(in_imm),
    .in_wb_en(in_wb_en), .in_is_load(in_is_load),
    .rf_read_a(rf_read_a), .rf_read_b(rf_read_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .ex_wb_en(ex_wb_en), .ex_dest(ex_dest), .ex_data(ex_data), .ex_is_load(ex_is_load),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_rd(out_rd),
    .out_wb_en(out_wb_en), .out_is_load(out_is_load)
  );

  typedef struct packed {
    logic       valid;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] imm;
    logic [3:0] rd;
    logic       wb_en;
    logic       is_load;
  } model_t;

  model_t m;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First source in the priority list that matches supplies the operand.
  function automatic logic [7:0] operand(input logic [3:0] s);
    logic       hit [3];
    logic [7:0] val [3];
    hit[0] = ex_wb_en && !ex_is_load && (ex_dest == s);  val[0] = ex_data;
    hit[1] = wb_wb_en && (wb_dest == s);                 val[1] = wb_data;
    hit[2] = 1'b1;                                       val[2] = rf[s];
    for (int i = 0; i < 3; i++) if (hit[i]) return val[i];
    return 8'hxx;
  endfunction

  task automatic check_outputs(input string ph);
    check({ph, "_out_valid"},   out_valid,   m.valid);
    check({ph, "_out_op"},      out_op,      m.op);
    check({ph, "_out_a"},       out_a,       m.a);
    check({ph, "_out_b"},       out_b,       m.b);
    check({ph, "_out_imm"},     out_imm,     m.imm);
    check({ph, "_out_rd"},      out_rd,      m.rd);
    check({ph, "_out_wb_en"},   out_wb_en,   m.wb_en);
    check({ph, "_out_is_load"}, out_is_load, m.is_load);
`ifdef OF_STALL_CNT_EN
    check({ph, "_stall_cnt"},   stall_cnt,   m_cnt);
`endif
  endtask

  // One clock: check combinational outputs, predict the edge, then check registered outputs.
  task automatic cycle(input string ph);
    model_t     nxt;
    logic       hz, rdy, do_wr;
    logic [3:0] wr_idx;
    logic [7:0] wr_val;
`ifdef OF_STALL_CNT_EN
    logic [15:0] cnt_nxt;
`endif
    #1;
    hz  = in_valid && ex_wb_en && ex_is_load && (ex_dest == in_rs_a || ex_dest == in_rs_b);
    rdy = !rst && !flush && !hz && (!m.valid || out_ready);
    check({ph, "_in_ready"},  in_ready,  rdy);
    check({ph, "_rf_read_a"}, rf_read_a, in_rs_a);
    check({ph, "_rf_read_b"}, rf_read_b, in_rs_b);
    nxt = m;
    if (rst)                   nxt = '0;
    else if (flush)            nxt.valid = 1'b0;
    else if (in_valid && rdy)  nxt = '{valid: 1'b1, op: in_op, a: operand(in_rs_a),
                                      b: operand(in_rs_b), imm: in_imm, rd: in_rd,
                                      wb_en: in_wb_en, is_load: in_is_load};
    else if (out_ready)        nxt.valid = 1'b0;
`ifdef OF_STALL_CNT_EN
    cnt_nxt = m_cnt;
    if (rst) cnt_nxt = 16'd0;
    else if (hz && !flush && m_cnt != 16'hFFFF) cnt_nxt = m_cnt + 16'd1;
`endif
    do_wr  = wb_wb_en;
    wr_idx = wb_dest;
    wr_val = wb_data;
    @(posedge clk);
    #1;
    if (do_wr) rf[wr_idx] = wr_val;
    m = nxt;
`ifdef OF_STALL_CNT_EN
    m_cnt = cnt_nxt;
`endif
    check_outputs(ph);
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_op = 0; in_rs_a = 0; in_rs_b = 0; in_rd = 0;
    in_imm = 0; in_wb_en = 0; in_is_load = 0;
    ex_wb_en = 0; ex_dest = 0; ex_data = 0; ex_is_load = 0;
    wb_wb_en = 0; wb_dest = 0; wb_data = 0; out_ready = 1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'(i);
    m = '0;
`ifdef OF_STALL_CNT_EN
    m_cnt = 16'd0;
`endif
    idle();

    // Reset, then release with no input
    rst = 1; cycle("rst"); cycle("rst");
    rst = 0; cycle("idle");
    check("tp_reset_valid", out_valid, 0);
    check("tp_reset_a", out_a, 0);
    check("tp_reset_in_ready", in_ready, 1);

    // Plain register-file read
    in_valid = 1; in_op = 4'd2; in_rs_a = 4'd3; in_rs_b = 4'd5; in_rd = 4'd1; in_imm = 8'h10;
    cycle("rf_read");
    check("tp_rf_a", out_a, 8'd3);
    check("tp_rf_b", out_b, 8'd5);
    check("tp_rf_valid", out_valid, 1);

    // EX beats WB on the same index, then WB alone
    ex_wb_en = 1; ex_is_load = 0; ex_dest = 4'd3; ex_data = 8'hAA;
    wb_wb_en = 1; wb_dest = 4'd3; wb_data = 8'h55;
    cycle("fwd_ex");
    check("tp_fwd_ex", out_a, 8'hAA);
    ex_wb_en = 0;
    cycle("fwd_wb");
    check("tp_fwd_wb", out_a, 8'h55);
    wb_wb_en = 0;

    // Load-use hazard: one bubble, then load data arrives via WB
    in_rs_a = 4'd1; in_rs_b = 4'd5; in_op = 4'd4;
    ex_wb_en = 1; ex_is_load = 1; ex_dest = 4'd5; ex_data = 8'hEE;
    #1 check("tp_hazard_in_ready", in_ready, 0);
    cycle("hazard");
    check("tp_bubble_valid", out_valid, 0);
    ex_wb_en = 0; ex_is_load = 0;
    wb_wb_en = 1; wb_dest = 4'd5; wb_data = 8'h77;
    cycle("load_wb");
    check("tp_load_valid", out_valid, 1);
    check("tp_load_b", out_b, 8'h77);
`ifdef OF_STALL_CNT_EN
    check("tp_stall_cnt", stall_cnt, 16'd1);
`endif
    wb_wb_en = 0;

    // Backpressure hold for 3 cycles, then release
    in_op = 4'd7; in_rs_a = 4'd2; in_rs_b = 4'd6;
    cycle("cap7");
    out_ready = 0; in_op = 4'd9; in_imm = 8'h99;
    for (int i = 0; i < 3; i++) begin
      cycle("hold");
      check("tp_hold_op", out_op, 4'd7);
      check("tp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    cycle("release");
    check("tp_release_op", out_op, 4'd9);

    // Flush with a valid held instruction and a new offer
    out_ready = 0; in_op = 4'd12; flush = 1;
    cycle("flush");
    check("tp_flush_valid", out_valid, 0);
    check("tp_flush_op", out_op, 4'd9);
    flush = 0; out_ready = 1;

    // Reset in the middle of a hold
    in_op = 4'd3; in_imm = 8'h3C; cycle("cap3");
    out_ready = 0; cycle("hold2");
    rst = 1; cycle("rst_hold");
    check("tp_rst_valid", out_valid, 0);
    check("tp_rst_op", out_op, 0);
    check("tp_rst_imm", out_imm, 0);
    rst = 0; out_ready = 1;

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom % 64) == 0;
      flush      = ($urandom % 16) == 0;
      in_valid   = ($urandom % 4) != 0;
      in_op      = 4'($urandom);
      in_rs_a    = 4'($urandom_range(0, 3));
      in_rs_b    = 4'($urandom_range(0, 3));
      in_rd      = 4'($urandom);
      in_imm     = 8'($urandom);
      in_wb_en   = 1'($urandom);
      in_is_load = 1'($urandom);
      ex_wb_en   = 1'($urandom);
      ex_is_load = ($urandom % 3) == 0;
      ex_dest    = 4'($urandom_range(0, 3));
      ex_data    = 8'($urandom);
      wb_wb_en   = 1'($urandom);
      wb_dest    = 4'($urandom_range(0, 3));
      wb_data    = 8'($urandom);
      out_ready  = ($urandom % 4) != 0;
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
